// File: rtl/tree_frame_sequencer.sv
// Byte-serial feature frame assembler and class capture stage for the decision-tree classifier.
// Optional inter-byte idle timeout is enabled by defining TREE_SEQ_TIMEOUT_EN.
module tree_frame_sequencer #(
   parameter int NUM_FEATURES   = 5,
   parameter int CLASS_W        = 2,
   parameter int SETTLE_CYCLES  = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [7:0]                in_data,
   input  logic                      in_valid,
   input  logic                      in_sof,
   output logic                      in_ready,
   output logic [8*NUM_FEATURES-1:0] feat_vec,
   input  logic [CLASS_W-1:0]        class_in,
   output logic [CLASS_W-1:0]        out_class,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      frame_err,
   output logic [15:0]               frame_cnt
);

   localparam int IW = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
   localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam logic [IW-1:0] LAST_IDX    = IW'(NUM_FEATURES - 1);
   localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYCLES);

   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      SETTLE  = 2'd1,
      PRESENT = 2'd2
   } state_t;

   state_t                    state_r, state_s;
   logic [IW-1:0]             idx_r, idx_s, idx_wr_s;
   logic [SW-1:0]             cnt_r, cnt_s;
   logic [8*NUM_FEATURES-1:0] feat_s;
   logic [CLASS_W-1:0]        class_s;
   logic                      valid_s;
   logic                      err_s;
   logic                      capture_s;
   logic                      accept_s;

`ifdef TREE_SEQ_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] idle_r, idle_s;
`endif

   // in_ready is registered from the next state, so it always mirrors state_r == LOAD
   assign accept_s = in_valid & in_ready;
   assign idx_wr_s = in_sof ? {IW{1'b0}} : idx_r;

   // Next-state and next-output computation for the frame FSM
   always_comb begin
      state_s   = state_r;
      idx_s     = idx_r;
      cnt_s     = cnt_r;
      feat_s    = feat_vec;
      class_s   = out_class;
      valid_s   = out_valid;
      err_s     = 1'b0;
      capture_s = 1'b0;
`ifdef TREE_SEQ_TIMEOUT_EN
      idle_s    = {TW{1'b0}};
`endif
      case (state_r)
         LOAD: begin
            if (accept_s) begin
               // A start-of-frame byte restarts assembly; a partial frame is discarded
               err_s = in_sof & (idx_r != {IW{1'b0}});
               for (int k = 0; k < NUM_FEATURES; k++) begin
                  if (idx_wr_s == IW'(k)) begin
                     feat_s[8*k +: 8] = in_data;
                  end else begin
                     feat_s[8*k +: 8] = feat_s[8*k +: 8];
                  end
               end
               if (idx_wr_s == LAST_IDX) begin
                  idx_s   = {IW{1'b0}};
                  cnt_s   = SETTLE_INIT;
                  state_s = SETTLE;
               end else begin
                  idx_s   = idx_wr_s + IW'(1);
               end
            end else begin
`ifdef TREE_SEQ_TIMEOUT_EN
               if (idx_r == {IW{1'b0}}) begin
                  idle_s = {TW{1'b0}};
               end else if (idle_r == IDLE_LAST) begin
                  idle_s = {TW{1'b0}};
                  idx_s  = {IW{1'b0}};
                  err_s  = 1'b1;
               end else begin
                  idle_s = idle_r + TW'(1);
               end
`else
               idx_s = idx_r;
`endif
            end
         end
         SETTLE: begin
            if (cnt_r == {SW{1'b0}}) begin
               capture_s = 1'b1;
               class_s   = class_in;
               valid_s   = 1'b1;
               state_s   = PRESENT;
            end else begin
               cnt_s     = cnt_r - SW'(1);
            end
         end
         PRESENT: begin
            if (out_ready) begin
               valid_s = 1'b0;
               state_s = LOAD;
            end else begin
               valid_s = 1'b1;
            end
         end
         default: begin
            state_s = LOAD;
            idx_s   = {IW{1'b0}};
            valid_s = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= LOAD;
         idx_r     <= {IW{1'b0}};
         cnt_r     <= {SW{1'b0}};
         feat_vec  <= {(8*NUM_FEATURES){1'b0}};
         out_class <= {CLASS_W{1'b0}};
         out_valid <= 1'b0;
         frame_err <= 1'b0;
         frame_cnt <= 16'd0;
         in_ready  <= 1'b1;
      end else begin
         state_r   <= state_s;
         idx_r     <= idx_s;
         cnt_r     <= cnt_s;
         feat_vec  <= feat_s;
         out_class <= class_s;
         out_valid <= valid_s;
         frame_err <= err_s;
         in_ready  <= (state_s == LOAD);
         if (capture_s) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end

`ifdef TREE_SEQ_TIMEOUT_EN
   // Inter-byte idle counter
   always_ff @(posedge clk) begin
      if (rst) begin
         idle_r <= {TW{1'b0}};
      end else begin
         idle_r <= idle_s;
      end
   end
`endif

endmodule

// File: tb/tb_tree_frame_sequencer.sv
// Directed bench for tree_frame_sequencer: vector table for the main frame flow,
// hand sequences for back-pressure, sof errors, reset, counter wrap and timeout.
module tb_tree_frame_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_sof;
   logic        in_ready;
   logic [39:0] feat_vec;
   logic [1:0]  class_in;
   logic [1:0]  out_class;
   logic        out_valid;
   logic        out_ready;
   logic        frame_err;
   logic [15:0] frame_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   tree_frame_sequencer #(
      .NUM_FEATURES(5), .CLASS_W(2), .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(4)
   ) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
      .in_ready(in_ready), .feat_vec(feat_vec), .class_in(class_in), .out_class(out_class),
      .out_valid(out_valid), .out_ready(out_ready), .frame_err(frame_err), .frame_cnt(frame_cnt)
   );

   typedef struct {
      logic        v;
      logic        sof;
      logic [7:0]  d;
      logic        rdy;
      logic [1:0]  cls;
      logic        e_ir;
      logic        e_ov;
      logic [1:0]  e_oc;
      logic        e_err;
      logic [15:0] e_cnt;
      logic [39:0] e_feat;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic v, input logic sof, input logic [7:0] d,
                               input logic rdy, input logic [1:0] cls, input logic e_ir,
                               input logic e_ov, input logic [1:0] e_oc, input logic e_err,
                               input logic [15:0] e_cnt, input logic [39:0] e_feat);
      vec_t r;
      r.v = v; r.sof = sof; r.d = d; r.rdy = rdy; r.cls = cls;
      r.e_ir = e_ir; r.e_ov = e_ov; r.e_oc = e_oc; r.e_err = e_err;
      r.e_cnt = e_cnt; r.e_feat = e_feat;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_data  = 8'h00;
   endtask

   task automatic put(input logic [7:0] d, input logic s);
      in_valid = 1'b1;
      in_sof   = s;
      in_data  = d;
      tick();
      idle_in();
   endtask

   task automatic send_frame(input logic [7:0] base);
      for (int k = 0; k < 5; k++) put(base + 8'(k), (k == 0));
   endtask

   // call right after the edge that accepted the last byte
   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      chk(name, 64'(n), 64'd3);
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; out_ready = 1'b0; class_in = 2'd0;
      idle_in();
      tick(); tick();
      rst = 1'b0;
      chk("rst in_ready", 64'(in_ready), 64'd1);
      chk("rst out_valid", 64'(out_valid), 64'd0);
      chk("rst out_class", 64'(out_class), 64'd0);
      chk("rst frame_err", 64'(frame_err), 64'd0);
      chk("rst frame_cnt", 64'(frame_cnt), 64'd0);
      chk("rst feat_vec", 64'(feat_vec), 64'd0);

      // frame A (class 2, held, extra byte ignored), then back-to-back frame B (class 3)
      tbl.push_back(mk(1, 1, 8'h0A, 0, 0, 1, 0, 0, 0, 16'd0, 40'h000000000A));
      tbl.push_back(mk(1, 0, 8'h14, 0, 0, 1, 0, 0, 0, 16'd0, 40'h000000140A));
      tbl.push_back(mk(1, 0, 8'h1E, 0, 0, 1, 0, 0, 0, 16'd0, 40'h00001E140A));
      tbl.push_back(mk(1, 0, 8'h28, 0, 0, 1, 0, 0, 0, 16'd0, 40'h00281E140A));
      tbl.push_back(mk(1, 0, 8'h32, 0, 0, 0, 0, 0, 0, 16'd0, 40'h32281E140A));
      tbl.push_back(mk(0, 0, 8'h00, 0, 2, 0, 0, 0, 0, 16'd0, 40'h32281E140A));
      tbl.push_back(mk(0, 0, 8'h00, 0, 2, 0, 0, 0, 0, 16'd0, 40'h32281E140A));
      tbl.push_back(mk(0, 0, 8'h00, 0, 2, 0, 1, 2, 0, 16'd1, 40'h32281E140A));
      tbl.push_back(mk(1, 0, 8'hAA, 0, 1, 0, 1, 2, 0, 16'd1, 40'h32281E140A));
      tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 2, 0, 16'd1, 40'h32281E140A));
      tbl.push_back(mk(1, 1, 8'h01, 0, 1, 1, 0, 2, 0, 16'd1, 40'h32281E1401));
      tbl.push_back(mk(1, 0, 8'h02, 0, 1, 1, 0, 2, 0, 16'd1, 40'h32281E0201));
      tbl.push_back(mk(1, 0, 8'h03, 0, 1, 1, 0, 2, 0, 16'd1, 40'h3228030201));
      tbl.push_back(mk(1, 0, 8'h04, 0, 1, 1, 0, 2, 0, 16'd1, 40'h3204030201));
      tbl.push_back(mk(1, 0, 8'h05, 0, 1, 0, 0, 2, 0, 16'd1, 40'h0504030201));
      tbl.push_back(mk(0, 0, 8'h00, 0, 3, 0, 0, 2, 0, 16'd1, 40'h0504030201));
      tbl.push_back(mk(0, 0, 8'h00, 0, 3, 0, 0, 2, 0, 16'd1, 40'h0504030201));
      tbl.push_back(mk(0, 0, 8'h00, 0, 3, 0, 1, 3, 0, 16'd2, 40'h0504030201));
      tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 3, 0, 16'd2, 40'h0504030201));

      for (int i = 0; i < tbl.size(); i++) begin
         in_valid = tbl[i].v; in_sof = tbl[i].sof; in_data = tbl[i].d;
         out_ready = tbl[i].rdy; class_in = tbl[i].cls;
         tick();
         chk($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(tbl[i].e_ir));
         chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
         chk($sformatf("vec%0d out_class", i), 64'(out_class), 64'(tbl[i].e_oc));
         chk($sformatf("vec%0d frame_err", i), 64'(frame_err), 64'(tbl[i].e_err));
         chk($sformatf("vec%0d frame_cnt", i), 64'(frame_cnt), 64'(tbl[i].e_cnt));
         chk($sformatf("vec%0d feat_vec", i), 64'(feat_vec), 64'(tbl[i].e_feat));
      end
      idle_in(); out_ready = 1'b0;

      // back-pressure: 10 cycles with out_ready low while bytes are offered
      class_in = 2'd1;
      send_frame(8'h40);
      wait_valid("bp latency");
      for (int c = 0; c < 10; c++) begin
         in_valid = 1'b1; in_sof = (c == 0); in_data = 8'hE0 + 8'(c); class_in = 2'd2;
         tick();
         chk("bp out_valid", 64'(out_valid), 64'd1);
         chk("bp out_class", 64'(out_class), 64'd1);
         chk("bp in_ready", 64'(in_ready), 64'd0);
      end
      idle_in();
      chk("bp feat_vec", 64'(feat_vec), 64'h4443424140);
      handshake();
      chk("bp release out_valid", 64'(out_valid), 64'd0);
      chk("bp release in_ready", 64'(in_ready), 64'd1);
      chk("bp frame_cnt", 64'(frame_cnt), 64'd3);

      // sof arriving mid-frame restarts the frame
      put(8'h11, 1'b1); put(8'h22, 1'b0); put(8'h33, 1'b0);
      chk("sof pre err", 64'(frame_err), 64'd0);
      put(8'h77, 1'b1);
      chk("sof err pulse", 64'(frame_err), 64'd1);
      chk("sof byte0", 64'(feat_vec[7:0]), 64'h77);
      put(8'h88, 1'b0);
      chk("sof err cleared", 64'(frame_err), 64'd0);
      chk("sof in_ready mid", 64'(in_ready), 64'd1);
      put(8'h99, 1'b0); put(8'hAA, 1'b0); put(8'hBB, 1'b0);
      chk("sof frame done in_ready", 64'(in_ready), 64'd0);
      wait_valid("sof latency");
      chk("sof feat_vec", 64'(feat_vec), 64'hBBAA998877);
      chk("sof frame_cnt", 64'(frame_cnt), 64'd4);
      handshake();

      // reset during SETTLE
      send_frame(8'h60);
      tick();
      rst = 1'b1; tick(); rst = 1'b0;
      chk("rst settle out_valid", 64'(out_valid), 64'd0);
      chk("rst settle in_ready", 64'(in_ready), 64'd1);
      chk("rst settle frame_cnt", 64'(frame_cnt), 64'd0);
      chk("rst settle feat_vec", 64'(feat_vec), 64'd0);
      repeat (4) tick();
      chk("rst settle no late valid", 64'(out_valid), 64'd0);

      // reset during PRESENT
      class_in = 2'd3;
      send_frame(8'h70);
      wait_valid("pre-rst latency");
      rst = 1'b1; tick(); rst = 1'b0;
      chk("rst present out_valid", 64'(out_valid), 64'd0);
      chk("rst present in_ready", 64'(in_ready), 64'd1);
      chk("rst present frame_cnt", 64'(frame_cnt), 64'd0);
      chk("rst present feat_vec", 64'(feat_vec), 64'd0);
      chk("rst present out_class", 64'(out_class), 64'd0);

      // frame counter wrap
      force dut.frame_cnt = 16'hFFFF;
      #1;
      release dut.frame_cnt;
      #1;
      chk("wrap preload", 64'(frame_cnt), 64'hFFFF);
      send_frame(8'h80);
      wait_valid("wrap latency");
      chk("wrap frame_cnt", 64'(frame_cnt), 64'd0);
      handshake();

`ifdef TREE_SEQ_TIMEOUT_EN
      // 2 bytes then 4 idle cycles -> timeout
      put(8'h01, 1'b1); put(8'h02, 1'b0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("to idle no err", 64'(frame_err), 64'd0);
      end
      tick();
      chk("to err pulse", 64'(frame_err), 64'd1);
      tick();
      chk("to err one cycle", 64'(frame_err), 64'd0);
      put(8'h5A, 1'b0);
      chk("to restart byte0", 64'(feat_vec[7:0]), 64'h5A);
      put(8'h5B, 1'b0); put(8'h5C, 1'b0); put(8'h5D, 1'b0); put(8'h5E, 1'b0);
      wait_valid("to restart latency");
      chk("to restart feat", 64'(feat_vec), 64'h5E5D5C5B5A);
      handshake();
      // 3 idle cycles then a byte -> no timeout, counter cleared
      put(8'hC0, 1'b1); put(8'hC1, 1'b0);
      repeat (3) tick();
      put(8'hC2, 1'b0);
      chk("to byte wins", 64'(frame_err), 64'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("to counter cleared", 64'(frame_err), 64'd0);
      end
      put(8'hC3, 1'b0); put(8'hC4, 1'b0);
      wait_valid("to nonerr latency");
      chk("to nonerr feat", 64'(feat_vec), 64'hC4C3C2C1C0);
      handshake();
`else
      // without the timeout a partial frame waits indefinitely
      put(8'h01, 1'b1); put(8'h02, 1'b0);
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("no-to idle no err", 64'(frame_err), 64'd0);
      end
      put(8'h03, 1'b0); put(8'h04, 1'b0); put(8'h05, 1'b0);
      wait_valid("no-to latency");
      chk("no-to feat", 64'(feat_vec), 64'h0504030201);
      handshake();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
